// File: rtl/axi_lite_mem_arbiter.sv
// Shares one AXI-Lite master port between the fetch (read-only) and data requesters.
// Only one transaction is in flight; each requester is stalled until its own completion pulse.
module axi_lite_mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ARB_MODE = 0
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_ready,
  output logic                inst_stall_req,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_ready,
  output logic                data_stall_req,
  output logic                bus_err,
  output logic [ADDR_W-1:0]   araddr,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  localparam int STRB_W = DATA_W / 8;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AR   = 3'd1;
  localparam logic [2:0] S_R    = 3'd2;
  localparam logic [2:0] S_AW_W = 3'd3;
  localparam logic [2:0] S_B    = 3'd4;
  localparam logic [2:0] S_RESP = 3'd5;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic              gnt_data;
  logic              last_data;
  logic              aw_done;
  logic              w_done;
  logic              pick_data;
  logic              grant;
  logic              aw_hs;
  logic              w_hs;
  logic [1:0]        resp_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [DATA_W-1:0] inst_rdata_q;
  logic [DATA_W-1:0] data_rdata_q;

  // Arbitration: a lone requester wins; on contention mode 0 favours data, mode 1 alternates.
  always_comb begin
    pick_data = 1'b0;
    if (data_req && !inst_req) begin
      pick_data = 1'b1;
    end else if (data_req && inst_req) begin
      pick_data = (ARB_MODE == 0) ? 1'b1 : !last_data;
    end
  end

  assign grant = (state == S_IDLE) && (inst_req || data_req);
  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (grant) state_nxt = (pick_data && data_wr) ? S_AW_W : S_AR;
      S_AR:   if (arready) state_nxt = S_R;
      S_R:    if (rvalid) state_nxt = S_RESP;
      S_AW_W: if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = S_B;
      S_B:    if (bvalid) state_nxt = S_RESP;
      S_RESP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      gnt_data     <= 1'b0;
      last_data    <= 1'b0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (grant) gnt_data <= pick_data;
      if (state == S_RESP) last_data <= gnt_data;
      if (state == S_IDLE) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else if (state == S_AW_W) begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs) w_done <= 1'b1;
      end
      if (state == S_R && rvalid) begin
        if (gnt_data) data_rdata_q <= rdata;
        else          inst_rdata_q <= rdata;
      end
    end
  end

  // Payload is captured once at grant so the AXI side never follows live requester inputs.
  always_ff @(posedge clk) begin
    if (grant) begin
      addr_q  <= pick_data ? data_addr : inst_addr;
      wdata_q <= data_wdata;
      wstrb_q <= data_wstrb;
    end
    if (state == S_R && rvalid) resp_q <= rresp;
    if (state == S_B && bvalid) resp_q <= bresp;
  end

  assign arvalid = (state == S_AR);
  assign araddr  = addr_q;
  assign rready  = (state == S_R);
  assign awvalid = (state == S_AW_W) && !aw_done;
  assign awaddr  = addr_q;
  assign wvalid  = (state == S_AW_W) && !w_done;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign bready  = (state == S_B);

  assign inst_ready     = (state == S_RESP) && !gnt_data;
  assign data_ready     = (state == S_RESP) && gnt_data;
  assign bus_err        = (state == S_RESP) && (resp_q != 2'b00);
  assign inst_rdata     = inst_rdata_q;
  assign data_rdata     = data_rdata_q;
  assign inst_stall_req = inst_req && !inst_ready;
  assign data_stall_req = data_req && !data_ready;

endmodule

// File: tb/tb_axi_lite_mem_arbiter.sv
// Bench for axi_lite_mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (a read returns mem_word(addr); writes must reach the bus intact).
module tb_axi_lite_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        inst_req, inst_ready, inst_stall_req;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_ready, data_stall_req, bus_err;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;

  logic        m1_inst_req, m1_inst_ready, m1_inst_stall_req;
  logic [31:0] m1_inst_addr, m1_inst_rdata;
  logic        m1_data_req, m1_data_wr, m1_data_ready, m1_data_stall_req, m1_bus_err;
  logic [3:0]  m1_data_wstrb, m1_wstrb;
  logic [31:0] m1_data_addr, m1_data_wdata, m1_data_rdata;
  logic [31:0] m1_araddr, m1_rdata, m1_awaddr, m1_wdata, m1_ar_addr;
  logic        m1_arvalid, m1_rvalid, m1_rready, m1_awvalid, m1_wvalid, m1_bvalid, m1_bready;
  logic        m1_arready, m1_awready, m1_wready;
  logic [1:0]  m1_rresp, m1_bresp;

  int n_cmp, n_bad;
  int ar_dly, r_dly, aw_dly, w_dly, b_dly;
  bit rand_dly, rand_resp;
  logic [1:0] rresp_set, bresp_set;

  int ar_hs, aw_hs, w_hs;
  logic [31:0] last_ar_addr, last_aw_addr, last_wdata;
  logic [3:0]  last_wstrb;
  logic [1:0]  last_resp;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h3C1D_0000;
  endfunction

  axi_lite_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .ARB_MODE(0)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ready(inst_ready),
    .inst_stall_req(inst_stall_req),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_ready(data_ready),
    .data_stall_req(data_stall_req), .bus_err(bus_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  axi_lite_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .ARB_MODE(1)) dut_rr (
    .clk(clk), .resetn(resetn),
    .inst_req(m1_inst_req), .inst_addr(m1_inst_addr), .inst_rdata(m1_inst_rdata),
    .inst_ready(m1_inst_ready), .inst_stall_req(m1_inst_stall_req),
    .data_req(m1_data_req), .data_wr(m1_data_wr), .data_wstrb(m1_data_wstrb),
    .data_addr(m1_data_addr), .data_wdata(m1_data_wdata), .data_rdata(m1_data_rdata),
    .data_ready(m1_data_ready), .data_stall_req(m1_data_stall_req), .bus_err(m1_bus_err),
    .araddr(m1_araddr), .arvalid(m1_arvalid), .arready(m1_arready),
    .rdata(m1_rdata), .rresp(m1_rresp), .rvalid(m1_rvalid), .rready(m1_rready),
    .awaddr(m1_awaddr), .awvalid(m1_awvalid), .awready(m1_awready),
    .wdata(m1_wdata), .wstrb(m1_wstrb), .wvalid(m1_wvalid), .wready(m1_wready),
    .bresp(m1_bresp), .bvalid(m1_bvalid), .bready(m1_bready)
  );

  // Always-ready slave for the round-robin instance.
  assign m1_arready = 1'b1;
  assign m1_rvalid  = 1'b1;
  assign m1_rresp   = 2'b00;
  assign m1_awready = 1'b1;
  assign m1_wready  = 1'b1;
  assign m1_bvalid  = 1'b1;
  assign m1_bresp   = 2'b00;
  assign m1_rdata   = mem_word(m1_ar_addr);
  always @(posedge clk) if (m1_arvalid) m1_ar_addr <= m1_araddr;

  // Handshake monitor for the main instance.
  always @(posedge clk) begin
    if (resetn) begin
      if (arvalid && arready) begin ar_hs <= ar_hs + 1; last_ar_addr <= araddr; end
      if (rvalid && rready) last_resp <= rresp;
      if (awvalid && awready) begin aw_hs <= aw_hs + 1; last_aw_addr <= awaddr; end
      if (wvalid && wready) begin w_hs <= w_hs + 1; last_wdata <= wdata; last_wstrb <= wstrb; end
      if (bvalid && bready) last_resp <= bresp;
    end
  end

  // Main slave: drives its ready/valid signals on the falling edge with programmable delays.
  task automatic slave_proc();
    int ar_c, r_c, aw_c, w_c, b_c, ar_l, r_l, aw_l, w_l, b_l;
    ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
    ar_l = 0; r_l = 0; aw_l = 0; w_l = 0; b_l = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0; awready = 0; wready = 0; bvalid = 0; bresp = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
      end else begin
        if (arvalid) begin
          if (ar_c == 0) ar_l = rand_dly ? int'($urandom_range(0, 3)) : ar_dly;
          if (ar_c >= ar_l) begin arready = 1; ar_c = 0; end else begin arready = 0; ar_c++; end
        end else begin arready = 0; ar_c = 0; end
        if (rready) begin
          if (r_c == 0) r_l = rand_dly ? int'($urandom_range(0, 3)) : r_dly;
          if (r_c >= r_l) begin
            rvalid = 1; rdata = mem_word(last_ar_addr);
            rresp = rand_resp ? 2'($urandom_range(0, 3)) : rresp_set; r_c = 0;
          end else begin rvalid = 0; r_c++; end
        end else begin rvalid = 0; r_c = 0; end
        if (awvalid) begin
          if (aw_c == 0) aw_l = rand_dly ? int'($urandom_range(0, 3)) : aw_dly;
          if (aw_c >= aw_l) begin awready = 1; aw_c = 0; end else begin awready = 0; aw_c++; end
        end else begin awready = 0; aw_c = 0; end
        if (wvalid) begin
          if (w_c == 0) w_l = rand_dly ? int'($urandom_range(0, 3)) : w_dly;
          if (w_c >= w_l) begin wready = 1; w_c = 0; end else begin wready = 0; w_c++; end
        end else begin wready = 0; w_c = 0; end
        if (bready) begin
          if (b_c == 0) b_l = rand_dly ? int'($urandom_range(0, 3)) : b_dly;
          if (b_c >= b_l) begin
            bvalid = 1; bresp = rand_resp ? 2'($urandom_range(0, 3)) : bresp_set; b_c = 0;
          end else begin bvalid = 0; b_c++; end
        end else begin bvalid = 0; b_c = 0; end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_cmp++; if ({arvalid, rready, awvalid, wvalid, bready} !== 5'b0) begin n_bad++; $display("FAIL reset_axi: got %b expected 00000", {arvalid, rready, awvalid, wvalid, bready}); end
    n_cmp++; if ({inst_ready, data_ready, bus_err} !== 3'b0) begin n_bad++; $display("FAIL reset_ready: got %b expected 000", {inst_ready, data_ready, bus_err}); end
    n_cmp++; if (inst_rdata !== 32'h0 || data_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h/%h expected 0/0", inst_rdata, data_rdata); end
    n_cmp++; if ({m1_arvalid, m1_rready, m1_awvalid, m1_wvalid, m1_bready, m1_inst_ready, m1_data_ready} !== 7'b0) begin n_bad++; $display("FAIL reset_rr: got %b expected 0", {m1_arvalid, m1_rready, m1_awvalid, m1_wvalid, m1_bready, m1_inst_ready, m1_data_ready}); end
    resetn = 1;
    tick();
  endtask

  task automatic test_single_fetch();
    int hs0;
    hs0 = ar_hs;
    inst_addr = 32'hBFC0_0000; inst_req = 1;
    #1;
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        n_cmp++; if (arvalid !== 1'b1 || araddr !== 32'hBFC0_0000) begin n_bad++; $display("FAIL fetch_ar: got %b/%h expected 1/bfc00000", arvalid, araddr); end
      end
      n_cmp++; if (inst_ready !== (c == 3)) begin n_bad++; $display("FAIL fetch_ready c%0d: got %b expected %b", c, inst_ready, (c == 3)); end
      n_cmp++; if (inst_stall_req !== (c < 3)) begin n_bad++; $display("FAIL fetch_stall c%0d: got %b expected %b", c, inst_stall_req, (c < 3)); end
      if (c >= 3) begin
        n_cmp++; if (inst_rdata !== 32'h3C1D_BFC0) begin n_bad++; $display("FAIL fetch_rdata c%0d: got %h expected 3c1dbfc0", c, inst_rdata); end
      end
      if (c == 3) inst_req = 0;
      tick();
    end
    n_cmp++; if (ar_hs - hs0 !== 1) begin n_bad++; $display("FAIL fetch_ar_count: got %0d expected 1", ar_hs - hs0); end
  endtask

  task automatic test_data_write();
    int aw0, w0;
    aw0 = aw_hs; w0 = w_hs;
    aw_dly = 2; w_dly = 0; b_dly = 0; bresp_set = 2'b00;
    data_addr = 32'h8000_1000; data_wdata = 32'hDEAD_BEEF; data_wstrb = 4'b0011; data_wr = 1; data_req = 1;
    #1;
    for (int c = 0; c < 7; c++) begin
      n_cmp++; if (awvalid !== (c >= 1 && c <= 3)) begin n_bad++; $display("FAIL wr_awvalid c%0d: got %b expected %b", c, awvalid, (c >= 1 && c <= 3)); end
      n_cmp++; if (wvalid !== (c == 1)) begin n_bad++; $display("FAIL wr_wvalid c%0d: got %b expected %b", c, wvalid, (c == 1)); end
      n_cmp++; if (bready !== (c == 4)) begin n_bad++; $display("FAIL wr_bready c%0d: got %b expected %b", c, bready, (c == 4)); end
      n_cmp++; if (data_ready !== (c == 5)) begin n_bad++; $display("FAIL wr_ready c%0d: got %b expected %b", c, data_ready, (c == 5)); end
      if (c == 5) begin
        n_cmp++; if (bus_err !== 1'b0) begin n_bad++; $display("FAIL wr_buserr: got %b expected 0", bus_err); end
        data_req = 0; data_wr = 0;
      end
      tick();
    end
    n_cmp++; if (aw_hs - aw0 !== 1 || w_hs - w0 !== 1) begin n_bad++; $display("FAIL wr_hs_count: got aw %0d w %0d expected 1 1", aw_hs - aw0, w_hs - w0); end
    n_cmp++; if (last_aw_addr !== 32'h8000_1000 || last_wdata !== 32'hDEAD_BEEF || last_wstrb !== 4'b0011) begin n_bad++; $display("FAIL wr_payload: got %h %h %b expected 80001000 deadbeef 0011", last_aw_addr, last_wdata, last_wstrb); end
    aw_dly = 0;
  endtask

  task automatic test_fixed_priority();
    data_addr = 32'h0000_2040; data_wr = 0; data_req = 1;
    inst_addr = 32'hBFC0_0010; inst_req = 1;
    #1;
    for (int c = 0; c < 9; c++) begin
      n_cmp++; if (data_ready !== (c == 3) || inst_ready !== (c == 7)) begin n_bad++; $display("FAIL prio_order c%0d: got d%b i%b expected d%b i%b", c, data_ready, inst_ready, (c == 3), (c == 7)); end
      n_cmp++; if (inst_stall_req !== (c < 7)) begin n_bad++; $display("FAIL prio_istall c%0d: got %b expected %b", c, inst_stall_req, (c < 7)); end
      if (c == 3) begin
        n_cmp++; if (data_rdata !== mem_word(32'h0000_2040)) begin n_bad++; $display("FAIL prio_drdata: got %h expected %h", data_rdata, mem_word(32'h0000_2040)); end
        data_req = 0;
      end
      if (c == 7) begin
        n_cmp++; if (inst_rdata !== mem_word(32'hBFC0_0010)) begin n_bad++; $display("FAIL prio_irdata: got %h expected %h", inst_rdata, mem_word(32'hBFC0_0010)); end
        inst_req = 0;
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    bit last_was_data, data_first;
    int t_d, t_i;
    last_was_data = 0;
    for (int r = 0; r < 2; r++) begin
      data_first = !last_was_data;
      t_d = data_first ? 3 : 7;
      t_i = data_first ? 7 : 3;
      m1_data_addr = 32'h0000_3000 + 32'(r * 16); m1_inst_addr = 32'h0040_0000 + 32'(r * 16);
      m1_data_req = 1; m1_inst_req = 1;
      #1;
      for (int c = 0; c < 9; c++) begin
        n_cmp++; if (m1_data_ready !== (c == t_d) || m1_inst_ready !== (c == t_i)) begin n_bad++; $display("FAIL rr_order r%0d c%0d: got d%b i%b expected d%b i%b", r, c, m1_data_ready, m1_inst_ready, (c == t_d), (c == t_i)); end
        if (c == t_d) begin
          n_cmp++; if (m1_data_rdata !== mem_word(m1_data_addr)) begin n_bad++; $display("FAIL rr_drdata r%0d: got %h expected %h", r, m1_data_rdata, mem_word(m1_data_addr)); end
          m1_data_req = 0;
        end
        if (c == t_i) begin
          n_cmp++; if (m1_inst_rdata !== mem_word(m1_inst_addr)) begin n_bad++; $display("FAIL rr_irdata r%0d: got %h expected %h", r, m1_inst_rdata, mem_word(m1_inst_addr)); end
          m1_inst_req = 0;
        end
        tick();
      end
      last_was_data = !data_first;
      if (r == 0) begin
        m1_data_addr = 32'h0000_3100; m1_data_req = 1;
        #1;
        for (int c = 0; c < 5; c++) begin
          n_cmp++; if (m1_data_ready !== (c == 3)) begin n_bad++; $display("FAIL rr_solo c%0d: got %b expected %b", c, m1_data_ready, (c == 3)); end
          if (c == 3) m1_data_req = 0;
          tick();
        end
        last_was_data = 1;
      end
    end
  endtask

  task automatic test_back_to_back();
    int hs0, k;
    bit exp_rdy;
    hs0 = ar_hs; k = 0;
    inst_addr = 32'h0001_0000; inst_req = 1;
    #1;
    for (int c = 0; c < 13; c++) begin
      exp_rdy = (c == 3 || c == 7 || c == 11);
      n_cmp++; if (inst_ready !== exp_rdy) begin n_bad++; $display("FAIL b2b_ready c%0d: got %b expected %b", c, inst_ready, exp_rdy); end
      n_cmp++; if (arvalid !== (c % 4 == 1 && c < 12)) begin n_bad++; $display("FAIL b2b_arvalid c%0d: got %b expected %b", c, arvalid, (c % 4 == 1 && c < 12)); end
      n_cmp++; if (inst_stall_req !== (c <= 11 && !exp_rdy)) begin n_bad++; $display("FAIL b2b_stall c%0d: got %b expected %b", c, inst_stall_req, (c <= 11 && !exp_rdy)); end
      if (exp_rdy) begin
        n_cmp++; if (inst_rdata !== mem_word(inst_addr)) begin n_bad++; $display("FAIL b2b_rdata k%0d: got %h expected %h", k, inst_rdata, mem_word(inst_addr)); end
        k++;
        if (k < 3) inst_addr = inst_addr + 32'h4;
        else inst_req = 0;
      end
      tick();
    end
    n_cmp++; if (ar_hs - hs0 !== 3) begin n_bad++; $display("FAIL b2b_ar_count: got %0d expected 3", ar_hs - hs0); end
  endtask

  task automatic test_bus_err();
    for (int n = 0; n < 2; n++) begin
      rresp_set = (n == 0) ? 2'b10 : 2'b00;
      data_addr = 32'h1000_0080 + 32'(n * 4); data_wr = 0; data_req = 1;
      #1;
      for (int c = 0; c < 5; c++) begin
        n_cmp++; if (data_ready !== (c == 3)) begin n_bad++; $display("FAIL err_ready n%0d c%0d: got %b expected %b", n, c, data_ready, (c == 3)); end
        n_cmp++; if (bus_err !== (c == 3 && n == 0)) begin n_bad++; $display("FAIL err_flag n%0d c%0d: got %b expected %b", n, c, bus_err, (c == 3 && n == 0)); end
        if (c == 3) begin
          n_cmp++; if (data_rdata !== mem_word(data_addr)) begin n_bad++; $display("FAIL err_rdata n%0d: got %h expected %h", n, data_rdata, mem_word(data_addr)); end
          data_req = 0;
        end
        tick();
      end
    end
  endtask

  task automatic test_reset_mid();
    r_dly = 30;
    data_addr = 32'h2000_0010; data_wr = 0; data_req = 1;
    tick(); tick();
    n_cmp++; if (rready !== 1'b1) begin n_bad++; $display("FAIL rst_in_r: got %b expected 1", rready); end
    #2;
    resetn = 0; data_req = 0;
    #1;
    n_cmp++; if ({arvalid, rready, awvalid, wvalid, bready} !== 5'b0) begin n_bad++; $display("FAIL rst_async_axi: got %b expected 00000", {arvalid, rready, awvalid, wvalid, bready}); end
    n_cmp++; if (data_rdata !== 32'h0 || inst_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_async_rdata: got %h/%h expected 0/0", data_rdata, inst_rdata); end
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++; if ({data_ready, inst_ready, rready, bus_err} !== 4'b0) begin n_bad++; $display("FAIL rst_hold c%0d: got %b expected 0000", c, {data_ready, inst_ready, rready, bus_err}); end
    end
    resetn = 1; r_dly = 0;
    tick();
    data_addr = 32'h2000_0020; data_req = 1;
    #1;
    for (int c = 0; c < 5; c++) begin
      n_cmp++; if (data_ready !== (c == 3)) begin n_bad++; $display("FAIL rst_after c%0d: got %b expected %b", c, data_ready, (c == 3)); end
      if (c == 3) begin
        n_cmp++; if (data_rdata !== mem_word(32'h2000_0020)) begin n_bad++; $display("FAIL rst_after_rdata: got %h expected %h", data_rdata, mem_word(32'h2000_0020)); end
        data_req = 0;
      end
      tick();
    end
  endtask

  task automatic test_random();
    int n_tx, i_done, d_done, i_gap, d_gap, cyc;
    bit i_busy, d_busy, d_is_wr;
    logic [31:0] i_a, d_a, d_wd;
    logic [3:0] d_ws;
    n_tx = 16; i_done = 0; d_done = 0; i_gap = 0; d_gap = 1; cyc = 0;
    i_busy = 0; d_busy = 0; d_is_wr = 0; i_a = 0; d_a = 0; d_wd = 0; d_ws = 0;
    rand_dly = 1; rand_resp = 1;
    while ((i_done < n_tx || d_done < n_tx) && cyc < 4000) begin
      if (inst_ready && data_ready) begin
        n_cmp++; n_bad++; $display("FAIL rnd_double_ready cyc%0d: got both ready expected one", cyc);
      end
      if (inst_ready) begin
        n_cmp++; if (!i_busy || inst_rdata !== mem_word(i_a) || last_ar_addr !== i_a) begin n_bad++; $display("FAIL rnd_inst cyc%0d: got busy%b rdata %h ar %h expected rdata %h ar %h", cyc, i_busy, inst_rdata, last_ar_addr, mem_word(i_a), i_a); end
        n_cmp++; if (bus_err !== (last_resp != 2'b00)) begin n_bad++; $display("FAIL rnd_inst_err cyc%0d: got %b expected %b", cyc, bus_err, (last_resp != 2'b00)); end
        i_busy = 0; inst_req = 0; i_done++; i_gap = $urandom_range(0, 2);
      end
      if (data_ready) begin
        if (d_is_wr) begin
          n_cmp++; if (!d_busy || last_aw_addr !== d_a || last_wdata !== d_wd || last_wstrb !== d_ws) begin n_bad++; $display("FAIL rnd_write cyc%0d: got %h %h %b expected %h %h %b", cyc, last_aw_addr, last_wdata, last_wstrb, d_a, d_wd, d_ws); end
        end else begin
          n_cmp++; if (!d_busy || data_rdata !== mem_word(d_a) || last_ar_addr !== d_a) begin n_bad++; $display("FAIL rnd_read cyc%0d: got rdata %h ar %h expected %h %h", cyc, data_rdata, last_ar_addr, mem_word(d_a), d_a); end
        end
        n_cmp++; if (bus_err !== (last_resp != 2'b00)) begin n_bad++; $display("FAIL rnd_data_err cyc%0d: got %b expected %b", cyc, bus_err, (last_resp != 2'b00)); end
        d_busy = 0; data_req = 0; d_done++; d_gap = $urandom_range(0, 2);
      end
      if (!inst_ready && !data_ready) begin
        n_cmp++; if (bus_err !== 1'b0) begin n_bad++; $display("FAIL rnd_err_idle cyc%0d: got %b expected 0", cyc, bus_err); end
      end
      if (!i_busy && i_done < n_tx) begin
        if (i_gap == 0) begin
          i_a = $urandom & 32'hFFFF_FFFC; inst_addr = i_a; inst_req = 1; i_busy = 1;
        end else i_gap--;
      end
      if (!d_busy && d_done < n_tx) begin
        if (d_gap == 0) begin
          d_a = $urandom & 32'hFFFF_FFFC; d_wd = $urandom; d_ws = 4'($urandom_range(1, 15));
          d_is_wr = 1'($urandom_range(0, 1));
          data_addr = d_a; data_wdata = d_wd; data_wstrb = d_ws; data_wr = d_is_wr; data_req = 1; d_busy = 1;
        end else d_gap--;
      end
      tick();
      cyc++;
    end
    n_cmp++; if (i_done !== n_tx || d_done !== n_tx) begin n_bad++; $display("FAIL rnd_complete: got inst %0d data %0d expected %0d each", i_done, d_done, n_tx); end
    inst_req = 0; data_req = 0; rand_dly = 0; rand_resp = 0;
    repeat (3) tick();
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    resetn = 0;
    inst_req = 0; inst_addr = 0;
    data_req = 0; data_wr = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
    m1_inst_req = 0; m1_inst_addr = 0;
    m1_data_req = 0; m1_data_wr = 0; m1_data_wstrb = 0; m1_data_addr = 0; m1_data_wdata = 0;
    ar_dly = 0; r_dly = 0; aw_dly = 0; w_dly = 0; b_dly = 0;
    rand_dly = 0; rand_resp = 0; rresp_set = 2'b00; bresp_set = 2'b00;
    ar_hs = 0; aw_hs = 0; w_hs = 0;
    last_ar_addr = 0; last_aw_addr = 0; last_wdata = 0; last_wstrb = 0; last_resp = 0;
    m1_ar_addr = 0;
    fork
      slave_proc();
    join_none
    test_reset();
    test_single_fetch();
    test_data_write();
    test_fixed_priority();
    test_round_robin();
    test_back_to_back();
    test_bus_err();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_lite_mem_arbiter.md
Name: axi_lite_mem_arbiter

Overview:
- Shares the single AXI-Lite master port between the instruction-fetch requester (read-only) and the data-memory requester (read/write).
- Sequences one outstanding transaction at a time.
- Returns read data and completion pulses to the requesters.
- Drives per-requester stall requests into the pipeline stall controller, so IF/MEM freeze while their access is in flight.

Parameters:
ADDR_W, 32, address width of requesters and AXI-Lite address channels
DATA_W, 32, data width; strobe width is DATA_W/8
ARB_MODE, 0, 0 = fixed priority (data over inst); 1 = round-robin between the two requesters

Ports:
clk  in  1  system clock, all logic on rising edge
resetn  in  1  reset; one clock; reset is asynchronous and active-low
inst_req  in  1  fetch request; held high with inst_addr stable until inst_ready
inst_addr  in  ADDR_W  fetch address
inst_rdata  out  DATA_W  fetched word, valid when inst_ready=1
inst_ready  out  1  one-cycle completion pulse for the fetch
inst_stall_req  out  1  inst_req & ~inst_ready, to stall controller
data_req  in  1  data access request; held high with payload stable until data_ready
data_wr  in  1  1 = write, 0 = read
data_wstrb  in  DATA_W/8  write byte strobes
data_addr  in  ADDR_W  data address
data_wdata  in  DATA_W  write data
data_rdata  out  DATA_W  read word, valid when data_ready=1 and access was a read
data_ready  out  1  one-cycle completion pulse
data_stall_req  out  1  data_req & ~data_ready
bus_err  out  1  one-cycle pulse coincident with a ready pulse whose rresp/bresp != 2'b00
araddr/arvalid/arready, rdata/rresp/rvalid/rready, awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready  AXI-Lite master channels, standard directions and widths (ADDR_W, DATA_W, DATA_W/8, 2-bit resp)

Behaviour:
- States: IDLE, AR, R, AW_W, B, RESP.
- Reset (async, resetn=0):
  - State goes to IDLE; last_grant=inst.
  - All AXI valid/ready outputs are 0.
  - inst_ready, data_ready and bus_err are 0.
  - inst_rdata and data_rdata are 0.
  - Reset mid-transaction abandons the transaction; no ready pulse is issued.
- IDLE arbitration:
  - Only one requester high: that one is granted.
  - Both high, ARB_MODE=0: data is granted.
  - Both high, ARB_MODE=1: the requester not equal to last_grant is granted.
  - On grant, latch grant id, address, wr, wdata and wstrb into internal registers. AXI outputs are driven only from these registers.
  - Inst grant or data read: next state AR. Data write: next state AW_W.
- AR: arvalid=1, araddr=latched address. On arready go to R; arvalid drops the same edge.
- R: rready=1. On rvalid, capture rdata into the granted requester's rdata register, capture rresp, go to RESP.
- AW_W:
  - awvalid and wvalid are asserted together.
  - Each valid drops independently after its own handshake; either may complete first, or both in the same cycle.
  - When both have completed, go to B.
- B: bready=1. On bvalid, capture bresp and go to RESP.
- RESP:
  - The granted requester's ready is 1 for exactly this cycle.
  - bus_err=1 if the captured resp is non-zero.
  - Update last_grant; next state IDLE.
  - The requester may drop req in this cycle; no request is sampled in RESP, so there are no duplicates.
- Minimum latency, slave ready immediately:
  - Read: req seen in IDLE at cycle 0, ready at cycle 3, IDLE at cycle 4.
  - Write: req at cycle 0, AW_W at cycle 1, B at cycle 2, ready at cycle 3.
- A request arriving while the other requester is granted waits, and its stall_req stays high. Its payload is not sampled until its own grant.
- AXI valids, once asserted, are never withdrawn before handshake, even if the requester drops req (protocol rule; requester behaviour is undefined in that case).
- rdata registers hold their value until the next completed read for that requester.

Test Plan:
1. Single fetch, ARB_MODE=0, inst_addr=0xBFC00000, arready=1, rvalid=1 with rdata=0x3C1DBFC0 on the first R cycle -> araddr=0xBFC00000; inst_ready pulses at cycle 3 with inst_rdata=0x3C1DBFC0; inst_stall_req is 1 in cycles 0-2 and 0 in cycle 3.
2. Data write, addr=0x80001000, wdata=0xDEADBEEF, wstrb=4'b0011; awready delayed 2 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid after 3; bready asserted only in B; data_ready pulses once; no duplicate AW.
3. Simultaneous inst_req and data_req (read), ARB_MODE=0 -> data served first, inst second; inst_stall_req stays high throughout. Repeat with ARB_MODE=1 and last_grant=data -> inst served first, then data.
4. Back-to-back, with inst_req held high continuously across 3 fetches -> exactly 3 AR handshakes and 3 inst_ready pulses, each separated by the RESP and IDLE cycles.
5. Slave returns rresp=2'b10 on a data read -> data_ready and bus_err pulse in the same cycle; data_rdata updated; next access proceeds normally.
6. resetn asserted low while in R with rvalid pending -> all AXI valid/ready outputs 0 and state IDLE asynchronously; no ready pulse; after release, the next request completes normally.
